// File: rtl/mult_shift_add_pkg.sv
// mult_shift_add_pkg
// Shared definitions for the shift-and-add multiplier:
//   DEFAULT_DATA_WIDTH : default operand width
//   state_t            : controller states IDLE / CALC / FIX
//   cnt_width()        : width of the bit counter, wide enough to hold DATA_WIDTH
//   is_neg()           : sign helper, true when an operand must be negated
//                        to obtain its magnitude
package mult_shift_add_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic int cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  // An operand is treated as negative only in two's-complement mode.
  function automatic logic is_neg(input logic signed_mode, input logic msb);
    return signed_mode & msb;
  endfunction

endpackage

// File: rtl/mult_shift_add_ctrl.sv
// mult_shift_add_ctrl
// Controller FSM of the shift-and-add multiplier.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : operation request, honoured only in IDLE
//   rb_zero     : no multiplier bits remain
//   cnt_eq_max  : DATA_WIDTH bits have been processed
//   load        : capture operands this edge (IDLE and start)
//   add_shift   : process one multiplier bit this edge
//   fix         : apply sign and publish the product this edge
//   state       : current state, also used by the top for rdy/busy
//
// Handshake: an operation is accepted on a rising edge where rdy=1
// (state IDLE) and start=1. start in any other state is ignored.
module mult_shift_add_ctrl
  import mult_shift_add_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   rb_zero,
  input  logic   cnt_eq_max,
  output logic   load,
  output logic   add_shift,
  output logic   fix,
  output state_t state
);

  state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: if (rb_zero || cnt_eq_max) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    add_shift = 1'b0;
    fix       = 1'b0;
    case (state)
      IDLE: load      = start;
      CALC: add_shift = !rb_zero && !cnt_eq_max;
      FIX:  fix       = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_shift_add.sv
// mult_shift_add
// Sequential shift-and-add multiplier, unsigned or two's complement per
// operation, terminating early once the remaining multiplier bits are zero.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : request a multiply (sampled while rdy=1)
//   signed_mode  : 0 unsigned, 1 two's complement (sampled with start)
//   A, B         : multiplicand / multiplier (sampled with start)
//   P            : product of the last completed operation, held
//   rdy          : idle, accepting start, P valid
//   busy         : inverse of rdy
//   done         : one-cycle pulse when a new P first appears
module mult_shift_add
  import mult_shift_add_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  output logic [2*DATA_WIDTH-1:0] P,
  output logic                    rdy,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0]   rb;
  logic [2*DATA_WIDTH-1:0] rp;
  logic [CW-1:0]           cnt;
  logic                    neg;

  logic   load;
  logic   add_shift;
  logic   fix;
  state_t state;

  // Magnitudes; the most-negative value maps onto 2^(DATA_WIDTH-1), which
  // is still representable as an unsigned DATA_WIDTH-bit number.
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;

  assign a_mag = is_neg(signed_mode, A[DATA_WIDTH-1]) ? (~A + 1'b1) : A;
  assign b_mag = is_neg(signed_mode, B[DATA_WIDTH-1]) ? (~B + 1'b1) : B;

  mult_shift_add_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rb_zero    (rb == '0),
    .cnt_eq_max (cnt == CNT_MAX),
    .load       (load),
    .add_shift  (add_shift),
    .fix        (fix),
    .state      (state)
  );

  assign rdy  = (state == IDLE);
  assign busy = ~rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      rp   <= '0;
      cnt  <= '0;
      neg  <= 1'b0;
      P    <= '0;
      done <= 1'b0;
    end else begin
      done <= fix;
      if (load) begin
        ra  <= {{DATA_WIDTH{1'b0}}, a_mag};
        rb  <= b_mag;
        rp  <= '0;
        cnt <= '0;
        neg <= signed_mode & (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
      end
      if (add_shift) begin
        rp  <= rp + (rb[0] ? ra : '0);
        ra  <= ra << 1;
        rb  <= rb >> 1;
        cnt <= cnt + 1'b1;
      end
      // Negation wraps modulo 2^(2*DATA_WIDTH), giving the two's-complement product.
      if (fix) begin
        P <= neg ? (~rp + 1'b1) : rp;
      end
    end
  end

endmodule

// File: tb/tb_mult_shift_add.sv
// tb_mult_shift_add
// Directed self-checking bench for mult_shift_add at DATA_WIDTH=8.
module tb_mult_shift_add;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signed_mode;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2*W-1:0] p;
  logic          rdy;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  mult_shift_add #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (a),
    .B           (b),
    .P           (p),
    .rdy         (rdy),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Call just after an accepting edge; returns at the negedge where done=1.
  // lat counts rising edges after the accepting edge.
  task automatic wait_done(input string tag, output int lat, output logic busy_ok);
    logic found;
    found   = 1'b0;
    busy_ok = 1'b1;
    lat     = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
      if (!busy || rdy) busy_ok = 1'b0;
    end
    if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Caller is at a negedge; returns at a negedge one cycle after done.
  task automatic run_op(input string tag, input logic sm, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [2*W-1:0] exp_p,
                        input int exp_lat);
    int   lat;
    logic busy_ok;
    start       = 1'b1;
    signed_mode = sm;
    a           = av;
    b           = bv;
    @(posedge clk);
    #1;
    start       = 1'b0;
    // Operands may change freely while busy.
    a           = W'($urandom_range(0, 255));
    b           = W'($urandom_range(0, 255));
    signed_mode = ~sm;
    wait_done(tag, lat, busy_ok);
    check({tag, "_p"}, 32'(p), 32'(exp_p));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_rdy"}, 32'(rdy), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_p_hold"}, 32'(p), 32'(exp_p));
  endtask

  initial begin
    int   lat;
    int   ndone;
    logic busy_ok;

    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_p", 32'(p), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("u_05x04", 1'b0, 8'h05, 8'h04, 16'h0014, 5);
    run_op("u_ffxff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 10);
    run_op("s_fdx05", 1'b1, 8'hFD, 8'h05, 16'hFFF1, 5);
    run_op("u_fdx05", 1'b0, 8'hFD, 8'h05, 16'h04F1, 5);
    run_op("s_80x80", 1'b1, 8'h80, 8'h80, 16'h4000, 10);
    run_op("s_80x01", 1'b1, 8'h80, 8'h01, 16'hFF80, 3);
    run_op("u_7fx00", 1'b0, 8'h7F, 8'h00, 16'h0000, 2);
    run_op("s_7fxff", 1'b1, 8'h7F, 8'hFF, 16'hFF81, 3);

    // start pulsed while busy must be ignored
    start = 1'b1; signed_mode = 1'b0; a = 8'h0F; b = 8'h0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_p", 32'(p), 32'h00E1);
    check("ign_rdy", 32'(rdy), 32'd1);

    // back-to-back: start held high across done
    start = 1'b1; signed_mode = 1'b0; a = 8'h03; b = 8'h03;
    @(posedge clk);
    #1;
    wait_done("b2b_1", lat, busy_ok);
    check("b2b_1_p", 32'(p), 32'h0009);
    check("b2b_1_lat", 32'(lat), 32'd4);
    a = 8'h02; b = 8'h02;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_accept_busy", 32'(busy), 32'd1);
    check("b2b_done_gone", 32'(done), 32'd0);
    @(negedge clk);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        check("b2b_2_p", 32'(p), 32'h0004);
      end
      @(negedge clk);
    end
    check("b2b_2_ndone", 32'(ndone), 32'd1);

    // reset in the third CALC cycle
    start = 1'b1; signed_mode = 1'b0; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_p", 32'(p), 32'd0);
    check("mid_rst_rdy", 32'(rdy), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    check("mid_idle_rdy", 32'(rdy), 32'd1);

    run_op("u_07x06", 1'b0, 8'h07, 8'h06, 16'h002A, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
